gsim_mem_responder: RTL
=======================

Name: gsim_mem_responder

Overview:
Parametrised, cycle-accurate matrix-memory responder for the GSIM environment. It serves o_mem_rreq/o_mem_addr requests from the GSIM core with configurable read latency and configurable i_mem_rrdy backpressure (none, periodic, pseudo-random), and has a preload write port. It is synthesizable and sits between the core and the matrix storage. It replaces the fixed one-cycle, always-ready memory model.

Parameters:
DATA_W, 256, read/write data width in bits
ADDR_W, 10, address width
DEPTH, 1024, number of words; must be <= 2**ADDR_W
LATENCY, 2, cycles from accept edge to data-valid cycle; legal range 1..8
STALL_PERIOD, 4, periodic mode cycle length; must be >= 2
STALL_LEN, 1, periodic mode ready-low cycles per period; must be < STALL_PERIOD
LFSR_SEED, 16'hACE1, random-mode seed; must be nonzero

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_stall_mode  in  2  0=always ready, 1=periodic, 2=random, 3=treated as 0
i_mem_rreq  in  1  read request from core
i_mem_addr  in  ADDR_W  read address, sampled with i_mem_rreq
o_mem_rrdy  out  1  responder can accept a request this cycle
o_mem_dout  out  DATA_W  read data
o_mem_dout_vld  out  1  o_mem_dout valid this cycle
i_wen  in  1  preload write enable
i_waddr  in  ADDR_W  preload write address
i_wdata  in  DATA_W  preload write data
o_req_cnt  out  32  count of accepted reads, saturating at 32'hFFFF_FFFF
o_addr_err  out  1  sticky flag: an accepted read or write had address >= DEPTH

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising edge of i_clk.
- Reset values: o_mem_rrdy=0, o_mem_dout=0, o_mem_dout_vld=0, o_req_cnt=0, o_addr_err=0. The read pipeline is flushed, the stall counter is 0, and the LFSR is set to LFSR_SEED. Memory contents are not cleared.
- First cycle after reset deasserts: o_mem_rrdy follows the selected mode. Mode 0 gives 1.
- Accept: a request is accepted on any edge where i_mem_rreq=1 and o_mem_rrdy=1. When i_mem_rreq=1 and o_mem_rrdy=0, the request is ignored. The core must hold the request; the responder does not queue it.
- Latency:
  - A request accepted at edge E produces o_mem_dout_vld=1 with the data in the cycle after edge E+LATENCY-1.
  - LATENCY=1 means valid in the cycle right after acceptance.
  - Back-to-back accepts give back-to-back valids, one per cycle. The pipeline never stalls.
  - o_mem_dout_vld is high for exactly one cycle per accepted request.
  - o_mem_dout returns to 0 in cycles where it is not valid.
- Data: o_mem_dout = mem[addr] as sampled at acceptance. If addr >= DEPTH, the data is all zeros and o_addr_err is set.
- Read/write collision: a write and an accepted read to the same address on the same edge return the old data (read-before-write).
- Writes: mem[i_waddr] <= i_wdata when i_wen=1 and i_waddr < DEPTH, independent of reset and stall state. If i_waddr >= DEPTH the write is dropped and o_addr_err is set.
- Stall modes (rrdy is registered):
  - Mode 0: o_mem_rrdy=1 every cycle.
  - Mode 1: a free-running counter c runs 0..STALL_PERIOD-1 and wraps. o_mem_rrdy=0 when c < STALL_LEN, otherwise 1.
  - Mode 2: a 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle. o_mem_rrdy = lfsr[0] | lfsr[1], which gives about 75% ready.
  - Counter and LFSR advance in every mode. A mode change takes effect on the next edge.
- o_req_cnt increments by 1 per accepted request and holds at its maximum value.
- Reset mid-operation: all in-flight reads are discarded. The cycle after reset shows o_mem_dout_vld=0 and no late valids appear. o_req_cnt and o_addr_err clear.

Test Plan:
1. LATENCY=2, mode 0: preload mem[5]=A5.., accept rreq addr 5 at edge 10 -> dout_vld=1 with data A5.. in the cycle after edge 11 only; o_req_cnt=1.
2. Mode 0: 16 consecutive reads of addr 0..15 -> 16 consecutive valid cycles, data in address order, o_req_cnt=16.
3. Mode 1, PERIOD=4, LEN=1: rreq held high for 40 cycles -> rrdy low 1 of every 4 cycles, exactly 30 accepts, o_req_cnt=30.
4. Same-edge write mem[7]=B and read addr 7 (old value A) -> returns A; a later read of addr 7 returns B.
5. DEPTH=1000: read addr 1010 -> dout=0 with vld=1 and o_addr_err=1, which stays 1; a write to 1020 is dropped.
6. Reset asserted while 2 reads are in flight -> no dout_vld afterwards, rrdy=0 during reset, o_req_cnt=0; mode 2 rrdy sequence after reset is identical to the first run.

Source files
------------

// File: rtl/gsim_mem_responder.sv
// Matrix-memory responder for the GSIM core: fixed-latency read pipeline with
// selectable ready backpressure (always, periodic, LFSR) and a preload write port.
module gsim_mem_responder #(
    parameter int          DATA_W       = 256,
    parameter int          ADDR_W       = 10,
    parameter int          DEPTH        = 1024,
    parameter int          LATENCY      = 2,
    parameter int          STALL_PERIOD = 4,
    parameter int          STALL_LEN    = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_stall_mode,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [31:0]       o_req_cnt,
    output logic              o_addr_err
);
    localparam int              CW       = $clog2(STALL_PERIOD);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STALL_PERIOD - 1);
    localparam logic [CW-1:0]   CNT_LEN  = CW'(STALL_LEN);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]              mem_q [DEPTH];
    logic                           accept;
    logic                           raddr_ok;
    logic                           waddr_ok;
    logic [DATA_W-1:0]              rd_data;
    logic [LATENCY-1:0]             vld_q;
    logic [LATENCY-1:0][DATA_W-1:0] data_q;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic                           rrdy_q, rrdy_d;
    logic [31:0]                    req_cnt_q, req_cnt_d;
    logic                           err_q, err_d;

    assign raddr_ok = {1'b0, i_mem_addr} < DEPTH_L;
    assign waddr_ok = {1'b0, i_waddr} < DEPTH_L;
    assign accept   = i_mem_rreq & rrdy_q;

    // Storage is never reset; the combinational read below sees the pre-edge
    // contents, so a same-edge write and read returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_wen && waddr_ok) mem_q[i_waddr] <= i_wdata;
    end

    always_comb begin
        rd_data = '0;
        if (raddr_ok) rd_data = mem_q[i_mem_addr];
    end

    // Idle slots carry zero data so the output is 0 whenever it is not valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= accept;
            data_q[0] <= accept ? rd_data : '0;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k]  <= vld_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (i_stall_mode)
            2'd1:    rrdy_d = (cnt_q >= CNT_LEN);
            2'd2:    rrdy_d = lfsr_q[0] | lfsr_q[1];
            default: rrdy_d = 1'b1;
        endcase
        req_cnt_d = (accept && req_cnt_q != '1) ? req_cnt_q + 32'd1 : req_cnt_q;
        err_d     = err_q | (accept & ~raddr_ok) | (i_wen & ~waddr_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            rrdy_q    <= 1'b0;
            req_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            rrdy_q    <= rrdy_d;
            req_cnt_q <= req_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_mem_rrdy     = rrdy_q;
    assign o_mem_dout     = data_q[LATENCY-1];
    assign o_mem_dout_vld = vld_q[LATENCY-1];
    assign o_req_cnt      = req_cnt_q;
    assign o_addr_err     = err_q;

endmodule
